// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Framed byte-stream writer for a word-addressed instruction
//               memory. Accepts LEN_HI, LEN_LO (word count N), 4N data
//               bytes (each word MSB first) and a trailing XOR checksum byte.
//               Assembled words are written sequentially from word 0. The
//               CPU is held in reset until a load completes with a good
//               checksum.
// Ports       : clk       - system clock, rising edge
//               reset     - asynchronous, active-low
//               start     - arms a new load from IDLE, DONE or ERR
//               rx_data   - incoming byte
//               rx_valid  - rx_data valid this cycle
//               rx_ready  - loader accepts a byte this cycle
//               WrEn      - one-cycle write strobe per word
//               WrAddr    - byte address of the word, {word_idx, 2'b00}
//               WrData    - assembled instruction word
//               cpu_hold  - 1 keeps the CPU in reset
//               done      - load finished with good checksum (level)
//               error     - load failed (level)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        WrEn,
  output logic [31:0] WrAddr,
  output logic [31:0] WrData,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Memory capacity in words; a 17-bit compare covers every 16-bit N.
  localparam logic [16:0] c_capacity = 17'd1 << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_len;
  // One extra bit so a full-capacity load cannot wrap before the last word.
  logic [ADDR_WIDTH:0]   r_word_idx;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_asm;        // first three bytes of the current word
  logic [7:0]            r_chk;
  logic                  r_wr_en;
  logic [31:0]           r_wr_addr;
  logic [31:0]           r_wr_data;
  logic                  r_cpu_hold;
  logic                  r_done;
  logic                  r_error;

  logic                  w_accept;
  logic [15:0]           w_len;
  logic                  w_len_over;
  logic                  w_last_byte;
  logic                  w_last_word;

  assign w_accept    = rx_valid & rx_ready;
  assign w_len       = {r_len_hi, rx_data};
  assign w_len_over  = {1'b0, w_len} > c_capacity;
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_last_word = ((17'(r_word_idx) + 17'd1) == {1'b0, r_len});

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and rx_ready
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    rx_ready     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) w_state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (w_len == 16'd0)  w_state_next = S_CHK;
          else if (w_len_over) w_state_next = S_ERR;
          else                 w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && w_last_byte && w_last_word) w_state_next = S_CHK;
      end
      S_CHK: begin
        rx_ready = 1'b1;
        if (rx_valid) w_state_next = (rx_data == r_chk) ? S_DONE : S_ERR;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_hi   <= 8'd0;
      r_len      <= 16'd0;
      r_word_idx <= '0;
      r_byte_idx <= 2'd0;
      r_asm      <= 24'd0;
      r_chk      <= 8'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 32'd0;
      r_wr_data  <= 32'd0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_asm      <= 24'd0;
            r_chk      <= 8'd0;
            r_cpu_hold <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (w_accept) r_len_hi <= rx_data;
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len_over) r_error <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_asm      <= {r_asm[15:0], rx_data};
            r_chk      <= r_chk ^ rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte) begin
              r_wr_en    <= 1'b1;
              r_wr_data  <= {r_asm, rx_data};
              r_wr_addr  <= 32'({r_word_idx, 2'b00});
              r_word_idx <= r_word_idx + 1'b1;
            end
          end
        end
        S_CHK: begin
          if (w_accept) begin
            if (rx_data == r_chk) begin
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_error    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign WrEn     = r_wr_en;
  assign WrAddr   = r_wr_addr;
  assign WrData   = r_wr_data;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
  assign error    = r_error;

endmodule
`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Byte-stream writer for a writable instruction memory: the producer side of the word-addressed instruction store that the CPU fetches from. It accepts a framed byte stream and assembles 32-bit instruction words. It writes the words sequentially from word address 0 and verifies a checksum. The CPU is held in reset via cpu_hold until the load completes successfully.

Parameters:
ADDR_WIDTH, 8, word-address bits of the instruction memory (capacity 2^ADDR_WIDTH words; byte address bits [ADDR_WIDTH+1:2])

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low (reset==0 clears all state immediately)
start  input  1  single-cycle pulse; arms a new load from IDLE, DONE or ERR
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready
WrEn  output  1  instruction-memory write strobe, one cycle per word
WrAddr  output  32  byte address of the word being written, {word_idx, 2'b00}, upper bits 0
WrData  output  32  instruction word
cpu_hold  output  1  1 = keep CPU in reset
done  output  1  load finished with good checksum (level)
error  output  1  load failed (level)

Behaviour:
- Frame: LEN_HI, LEN_LO (16-bit word count N, MSB first), then 4N data bytes (each word MSB first), then 1 checksum byte = XOR of all 4N data bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
- Reset values: state IDLE, rx_ready 0, WrEn 0, WrAddr 0, WrData 0, cpu_hold 1, done 0, error 0; internal counters and checksum 0.
- IDLE/DONE/ERR + start -> LEN_HI. This clears done, error, word_idx, byte_idx and the checksum accumulator, and sets cpu_hold 1. start in any other state is ignored.
- rx_ready = 1 exactly in LEN_HI, LEN_LO, DATA, CHK (combinational from state). It stays 1 during the write cycle, so a byte may be accepted every cycle.
- LEN_HI: accept -> latch high byte, go to LEN_LO.
- LEN_LO: accept -> form N and compare against capacity. N==0 -> CHK, where the expected checksum is 0x00. N > 2^ADDR_WIDTH -> ERR. Otherwise -> DATA.
- DATA: each accepted byte shifts into a 32-bit assembly register (first byte lands in [31:24]), is XORed into the checksum, and increments the 2-bit byte_idx.
  - On the 4th byte, WrEn=1 on the next cycle for exactly one cycle, with WrData = the assembled word and WrAddr = word_idx<<2. word_idx then increments.
  - After word N-1 is accepted -> CHK.
  - Write latency is 1 cycle after the last byte of the word.
- CHK: accept byte. Equal to the accumulator -> DONE (done=1, cpu_hold=0). Mismatch -> ERR (error=1, cpu_hold stays 1).
- Words already written are not rolled back on ERR.
- Wrap: N == 2^ADDR_WIDTH is legal; word_idx must not overflow before the final compare (use an ADDR_WIDTH+1-bit counter or compare against N-1).
- rx_valid is ignored when rx_ready==0. Stalls (rx_valid low) of any length are allowed mid-word, and the partial word is retained.
- Reset asserted mid-load: immediate return to reset values; the partial word is discarded with no write.
- Outputs WrEn, WrAddr, WrData, done, error and cpu_hold are registered.

Test Plan:
- Reset -> rx_ready=0, cpu_hold=1, WrEn=0, done=0, error=0.
- Normal load: start, then bytes 00 02 | 20 04 00 04 | 0C 00 00 03 | 2F, back-to-back.
  - Required: WrEn pulses twice; (WrAddr=0x0, WrData=0x20040004) then (WrAddr=0x4, WrData=0x0C000003).
  - Each pulse comes one cycle after the 4th byte of its word.
  - Final state: done=1, cpu_hold=0, rx_ready=0.
- Bad checksum: same frame with final byte 0x2E -> both writes occur, then error=1, done=0, cpu_hold=1. A following start returns to LEN_HI with error cleared.
- Oversize length with ADDR_WIDTH=8: bytes 01 01 (N=257) -> error=1 right after LEN_LO, no WrEn, rx_ready=0. Length 01 00 (N=256) is accepted and the last write is at WrAddr=0x3FC.
- Zero length: 00 00 00 -> done=1 with no WrEn. 00 00 05 -> error=1.
- Stalls and reset:
  - Random rx_valid gaps inside a word -> identical writes to the back-to-back case.
  - start pulsed during DATA -> ignored.
  - reset low after 2 data bytes -> no write, all outputs at reset values.
  - A fresh load after reset succeeds.
